instr_encoder_loader: RTL and testbench

- Encoder counterpart of the opcode decoder. Accepts symbolic operation requests, packs them into 32-bit instruction words, and writes them sequentially into instruction memory.
- Encodes exactly the opcodes the decoder understands, with register fields placed where the datapath reads them, so decoded control matches the requested operation.
- Sits between the testbench or loader front-end and the instruction memory write port.
- Contains a small request FIFO, an address counter, and a load-sequencing FSM.

---
 rtl/instr_encoder_loader.sv | 160 ++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs symbolic operation requests into 32-bit instruction words, queues them in a
// small FIFO and writes them to sequential instruction-memory addresses.
module instr_encoder_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   instr_count,
    output logic              err_illegal,
    output logic              err_full
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic [ADDR_W-1:0] addr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_hs;
    logic              do_push;
    logic              do_pop;
    logic              last_addr;
    logic [31:0]       enc_word;

    function automatic logic kind_legal(input logic [2:0] kind);
        return kind < 3'd6;
    endfunction

    // R-type kinds carry rd in [15:11]; load/store carry the 16-bit offset instead.
    function automatic logic [31:0] encode(input logic [2:0] kind, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [15:0] imm);
        logic [31:0] w;
        w = '0;
        case (kind)
            3'd0:    w = {6'd1, rs, rt, rd, 11'd0};
            3'd1:    w = {6'd3, rs, rt, rd, 11'd0};
            3'd2:    w = {6'd5, rs, rt, rd, 11'd0};
            3'd3:    w = {6'd7, rs, rt, rd, 11'd0};
            3'd4:    w = {6'd4, rs, rt, imm};
            3'd5:    w = {6'd2, rs, rt, imm};
            default: w = '0;
        endcase
        return w;
    endfunction

    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign req_ready  = (state == RUN) && !fifo_full;
    assign busy       = (state == RUN) || (state == DRAIN);
    assign push_hs    = req_valid && req_ready;
    assign do_push    = push_hs && kind_legal(req_kind);
    assign do_pop     = busy && !fifo_empty && !err_full;
    assign last_addr  = (addr == {ADDR_W{1'b1}});
    assign enc_word   = encode(req_kind, req_rs, req_rt, req_rd, req_imm);

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            addr        <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            done        <= 1'b0;
            instr_count <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;

            if (do_pop) begin
                imem_we     <= 1'b1;
                imem_addr   <= addr;
                imem_wdata  <= fifo_mem[rd_ptr];
                instr_count <= instr_count + (ADDR_W+1)'(1);
                if (!last_addr) begin
                    addr <= addr + ADDR_W'(1);
                end
            end

            if (push_hs && !kind_legal(req_kind)) begin
                err_illegal <= 1'b1;
            end

            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        addr        <= base_addr;
                        instr_count <= '0;
                        err_illegal <= 1'b0;
                        err_full    <= 1'b0;
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        fifo_cnt    <= '0;
                    end
                end
                RUN: begin
                    if (finish) state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // The top address was just written: nothing further may go out, so flush and stop.
            if (do_pop && last_addr) begin
                err_full <= 1'b1;
                state    <= DONE;
                done     <= 1'b1;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: a queue-based behavioural model checked against the DUT every
// cycle, plus directed scenarios with hand-computed expected instruction words.
module tb_instr_encoder_loader;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int OPC [6] = '{1, 3, 5, 7, 4, 2};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          finish = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          req_valid = 1'b0;
    logic [2:0]    req_kind = '0;
    logic [4:0]    req_rs = '0, req_rt = '0, req_rd = '0;
    logic [15:0]   req_imm = '0;
    logic          req_ready, imem_we, busy, done, err_illegal, err_full;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   instr_count;

    int total = 0;
    int passed = 0;

    instr_encoder_loader #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .finish(finish),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .instr_count(instr_count),
        .err_illegal(err_illegal), .err_full(err_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input bit ok, input string detail);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 accepting, 2 draining, 3 finished
    int          m_mode = 0;
    logic [31:0] m_q [$];
    int          m_addr = 0;
    int          m_cnt = 0;
    bit          m_we = 0, m_done = 0, m_ill = 0, m_full = 0, m_valid = 0;
    int          m_waddr = 0;
    logic [31:0] m_wdata = '0;

    logic [7:0]  wlog_a [$];
    logic [31:0] wlog_d [$];
    int          done_seen = 0;

    function automatic logic [31:0] ref_word(int kind, int rs, int rt, int rd, int imm);
        int low;
        low = (kind < 4) ? (rd << 11) : imm;
        return 32'((OPC[kind] << 26) | (rs << 21) | (rt << 16) | low);
    endfunction

    task automatic model_step();
        int pre;
        bit pop, acc, limit;
        if (rst) begin
            m_mode = 0; m_q.delete(); m_addr = 0; m_cnt = 0;
            m_we = 0; m_done = 0; m_ill = 0; m_full = 0; m_waddr = 0; m_wdata = '0;
            m_valid = 1;
            return;
        end
        pre   = m_q.size();
        pop   = (m_mode == 1 || m_mode == 2) && pre > 0 && !m_full;
        acc   = req_valid && m_mode == 1 && pre < DEPTH;
        limit = 0;
        m_we = 0; m_done = 0;
        if (pop) begin
            m_wdata = m_q.pop_front();
            m_we    = 1;
            m_waddr = m_addr;
            m_cnt++;
            limit = (m_addr == (1 << AW) - 1);
            if (!limit) m_addr++;
        end
        if (acc) begin
            if (req_kind < 6) m_q.push_back(ref_word(req_kind, req_rs, req_rt, req_rd, req_imm));
            else m_ill = 1;
        end
        if ((m_mode == 0 || m_mode == 3) && start) begin
            m_mode = 1; m_addr = base_addr; m_cnt = 0; m_ill = 0; m_full = 0; m_q.delete();
        end else if (m_mode == 1 && finish) begin
            m_mode = 2;
        end else if (m_mode == 2 && pre == 0) begin
            m_mode = 3; m_done = 1;
        end
        if (limit) begin
            m_full = 1; m_q.delete(); m_mode = 3; m_done = 1;
        end
    endtask

    // Compare on the falling edge, then advance the model with the inputs the next rising edge samples.
    initial begin
        bit ok, exp_busy, exp_rdy;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                exp_busy = (m_mode == 1 || m_mode == 2);
                exp_rdy  = (m_mode == 1) && (m_q.size() < DEPTH);
                ok = (imem_we === m_we) && (imem_addr === AW'(m_waddr)) && (imem_wdata === m_wdata)
                     && (done === m_done) && (instr_count === (AW+1)'(m_cnt))
                     && (err_illegal === m_ill) && (err_full === m_full)
                     && (busy === exp_busy) && (req_ready === exp_rdy);
                chk("cycle", ok, $sformatf(
                    "t=%0t got we=%b a=%h d=%h done=%b cnt=%0d ill=%b full=%b busy=%b rdy=%b, want we=%b a=%h d=%h done=%b cnt=%0d ill=%b full=%b busy=%b rdy=%b",
                    $time, imem_we, imem_addr, imem_wdata, done, instr_count, err_illegal, err_full, busy, req_ready,
                    m_we, AW'(m_waddr), m_wdata, m_done, m_cnt, m_ill, m_full, exp_busy, exp_rdy));
                if (imem_we === 1'b1) begin
                    wlog_a.push_back(imem_addr);
                    wlog_d.push_back(imem_wdata);
                end
                if (done === 1'b1) done_seen++;
            end
            model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        start = 1'b1; base_addr = b;
        tick();
        start = 1'b0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic send(input int k, input int rs, input int rt, input int rd, input int imm);
        bit rdy;
        int n;
        n = 0;
        req_valid = 1'b1; req_kind = 3'(k); req_rs = 5'(rs); req_rt = 5'(rt);
        req_rd = 5'(rd); req_imm = 16'(imm);
        do begin
            @(negedge clk);
            rdy = req_ready;
            tick();
            n++;
        end while (!rdy && n < 100);
        req_valid = 1'b0;
        chk("send_accept", rdy, $sformatf("kind %0d not accepted within %0d cycles", k, n));
    endtask

    task automatic wait_done(input int prev);
        int n;
        n = 0;
        while (done_seen <= prev && n < 100) begin
            tick();
            n++;
        end
        chk("done_pulse", done_seen > prev, $sformatf("done count %0d, need > %0d", done_seen, prev));
    endtask

    function automatic bit outputs_zero();
        return imem_we === 1'b0 && imem_addr === '0 && imem_wdata === '0 && req_ready === 1'b0
            && busy === 1'b0 && done === 1'b0 && instr_count === '0
            && err_illegal === 1'b0 && err_full === 1'b0;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1, "timeout");
    end

    // ---------------- scenarios ----------------
    initial begin
        int n0, d0, n;
        logic [AW-1:0] b;

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_state", outputs_zero(), $sformatf("we=%b a=%h d=%h rdy=%b busy=%b cnt=%0d, want all 0",
            imem_we, imem_addr, imem_wdata, req_ready, busy, instr_count));
        rst = 1'b0;
        tick();

        // single R-type write
        n0 = wlog_a.size(); d0 = done_seen;
        do_start(8'h10);
        send(0, 2, 3, 4, 0);
        do_finish();
        wait_done(d0);
        chk("t1_nwrites", wlog_a.size() - n0 == 1, $sformatf("got %0d want 1", wlog_a.size() - n0));
        chk("t1_addr", wlog_a[n0] === 8'h10, $sformatf("got %h want 10", wlog_a[n0]));
        chk("t1_data", wlog_d[n0] === 32'h04432000, $sformatf("got %h want 04432000", wlog_d[n0]));
        chk("t1_count", instr_count === 9'd1, $sformatf("got %0d want 1", instr_count));

        // load then store
        n0 = wlog_a.size(); d0 = done_seen;
        do_start(8'h20);
        send(4, 1, 5, 0, 16'h0008);
        send(5, 1, 6, 0, 16'hFFFC);
        do_finish();
        wait_done(d0);
        chk("t2_load", wlog_a[n0] === 8'h20 && wlog_d[n0] === 32'h10250008,
            $sformatf("got %h@%h want 10250008@20", wlog_d[n0], wlog_a[n0]));
        chk("t2_store", wlog_a[n0+1] === 8'h21 && wlog_d[n0+1] === 32'h0826FFFC,
            $sformatf("got %h@%h want 0826fffc@21", wlog_d[n0+1], wlog_a[n0+1]));

        // illegal kind between two legal requests
        n0 = wlog_a.size(); d0 = done_seen;
        do_start(8'h30);
        send(0, 1, 2, 3, 0);
        send(6, 7, 7, 7, 16'h1234);
        send(1, 4, 5, 6, 0);
        do_finish();
        wait_done(d0);
        chk("t3_nwrites", wlog_a.size() - n0 == 2, $sformatf("got %0d want 2", wlog_a.size() - n0));
        chk("t3_illegal", err_illegal === 1'b1, $sformatf("got %b want 1", err_illegal));
        chk("t3_second", wlog_a[n0+1] === 8'h31 && wlog_d[n0+1] === 32'h0C853000,
            $sformatf("got %h@%h want 0c853000@31", wlog_d[n0+1], wlog_a[n0+1]));

        // address space exhaustion
        n0 = wlog_a.size(); d0 = done_seen;
        do_start(8'hFE);
        send(2, 1, 1, 1, 0);
        send(3, 2, 2, 2, 0);
        send(0, 3, 3, 3, 0);
        wait_done(d0);
        repeat (3) tick();
        chk("t4_nwrites", wlog_a.size() - n0 == 2, $sformatf("got %0d want 2", wlog_a.size() - n0));
        chk("t4_addrs", wlog_a[n0] === 8'hFE && wlog_a[n0+1] === 8'hFF,
            $sformatf("got %h,%h want fe,ff", wlog_a[n0], wlog_a[n0+1]));
        chk("t4_flags", err_full === 1'b1 && instr_count === 9'd2 && busy === 1'b0,
            $sformatf("got full=%b cnt=%0d busy=%b want 1,2,0", err_full, instr_count, busy));

        // randomized runs, some near the top of the address space
        for (int r = 0; r < 8; r++) begin
            b = (r % 3 == 2) ? AW'(248 + $urandom_range(0, 7)) : AW'($urandom);
            do_start(b);
            for (int c = 0; c < 80; c++) begin
                req_valid = ($urandom % 4) != 0;
                req_kind  = 3'($urandom);
                req_rs    = 5'($urandom);
                req_rt    = 5'($urandom);
                req_rd    = 5'($urandom);
                req_imm   = 16'($urandom);
                finish    = ($urandom % 50) == 0;
                start     = ($urandom % 60) == 0;
                base_addr = AW'($urandom);
                tick();
            end
            req_valid = 1'b0; start = 1'b0; finish = 1'b0;
            do_finish();
            n = 0;
            while (busy && n < 50) begin
                tick();
                n++;
            end
            chk("rand_idle", busy === 1'b0, $sformatf("round %0d busy=%b after drain", r, busy));
        end

        // reset while draining
        do_start(8'h40);
        req_valid = 1'b1; req_kind = 3'd0; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd3;
        tick();
        tick();
        finish = 1'b1;
        tick();
        finish = 1'b0; req_valid = 1'b0;
        chk("t6_draining", busy === 1'b1, $sformatf("got busy=%b want 1", busy));
        rst = 1'b1;
        tick();
        chk("t6_reset_mid_drain", outputs_zero(), $sformatf("we=%b a=%h d=%h busy=%b cnt=%0d, want all 0",
            imem_we, imem_addr, imem_wdata, busy, instr_count));
        rst = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
